// File: rtl/tx_mac_pkg.sv
// Shared MII/Ethernet definitions for the TX MAC and the future RX FCS checker.
package tx_mac_pkg;

  localparam logic [3:0]  PREAMBLE_NIB    = 4'h5;
  localparam logic [3:0]  SFD_NIB         = 4'hD;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_BODY,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/crc32_nibble.sv
// Reflected CRC-32 update for one nibble, LSB first; purely combinational.
module crc32_nibble
  import tx_mac_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nibble,
  output logic [31:0] next_crc
);

  always_comb begin
    next_crc = crc;
    for (int unsigned i = 0; i < 4; i++) begin
      if (next_crc[0] ^ nibble[i]) next_crc = (next_crc >> 1) ^ CRC32_POLY_REFL;
      else                         next_crc = next_crc >> 1;
    end
  end

endmodule

// File: rtl/tx_mac.sv
// 100M MII Ethernet TX MAC: preamble/SFD, zero pad, CRC-32 FCS and inter-frame gap.
module tx_mac
  import tx_mac_pkg::*;
#(
  parameter int unsigned PREAMBLE_NIBBLES = 15,
  parameter int unsigned MIN_BODY_NIBBLES = 120,
  parameter int unsigned IFG_NIBBLES      = 24
) (
  input  logic       clk_tx,
  input  logic       rst_n,
  input  logic       tx_vld,
  input  logic [3:0] tx_dat,
  input  logic       tx_eof,
  output logic       tx_rdy,
  output logic       tx_underrun,
  output logic       mii_tx_en,
  output logic [3:0] mii_txd
);

  // The IDLE edge already loads the first preamble nibble, so PRE runs one short.
  localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_NIBBLES - 2);
  localparam logic [4:0] IFG_LAST = 5'(IFG_NIBBLES - 1);
  localparam logic [6:0] MIN_BODY = 7'(MIN_BODY_NIBBLES);

  tx_state_t   state;
  logic [31:0] crc;
  logic [31:0] next_crc;
  logic [31:0] fcs_word;
  logic [3:0]  crc_nib;
  logic [3:0]  fcs_nib;
  logic [4:0]  cnt;
  logic [6:0]  body_cnt;
  logic [6:0]  body_inc;
  logic [2:0]  fcs_idx;

  assign crc_nib  = (state == ST_PAD) ? '0 : tx_dat;
  assign body_inc = body_cnt + 7'd1;
  assign fcs_word = ~crc;
  assign fcs_nib  = fcs_word[{fcs_idx, 2'b00} +: 4];

  crc32_nibble u_crc (
    .crc      (crc),
    .nibble   (crc_nib),
    .next_crc (next_crc)
  );

  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      crc         <= CRC32_INIT;
      cnt         <= '0;
      body_cnt    <= '0;
      fcs_idx     <= '0;
      tx_rdy      <= 1'b0;
      tx_underrun <= 1'b0;
      mii_tx_en   <= 1'b0;
      mii_txd     <= '0;
    end else begin
      tx_underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_vld) begin
            state     <= ST_PRE;
            mii_tx_en <= 1'b1;
            mii_txd   <= PREAMBLE_NIB;
            cnt       <= '0;
          end
        end
        ST_PRE: begin
          mii_txd <= PREAMBLE_NIB;
          cnt     <= cnt + 5'd1;
          if (cnt == PRE_LAST) state <= ST_SFD;
        end
        ST_SFD: begin
          mii_txd  <= SFD_NIB;
          crc      <= CRC32_INIT;
          body_cnt <= '0;
          tx_rdy   <= 1'b1;
          state    <= ST_BODY;
        end
        ST_BODY: begin
          if (tx_vld) begin
            mii_txd <= tx_dat;
            crc     <= next_crc;
            if (body_cnt != MIN_BODY) body_cnt <= body_inc;
            if (tx_eof) begin
              tx_rdy  <= 1'b0;
              fcs_idx <= '0;
              state   <= (body_inc < MIN_BODY) ? ST_PAD : ST_FCS;
            end
          end else begin
            // Underrun: this edge must already drive FCS nibble 0; storing ~crc makes
            // every FCS nibble the complement of the correct one.
            tx_underrun <= 1'b1;
            tx_rdy      <= 1'b0;
            crc         <= ~crc;
            mii_txd     <= crc[3:0];
            fcs_idx     <= 3'd1;
            state       <= ST_FCS;
          end
        end
        ST_PAD: begin
          mii_txd  <= '0;
          crc      <= next_crc;
          body_cnt <= body_inc;
          if (body_inc == MIN_BODY) begin
            fcs_idx <= '0;
            state   <= ST_FCS;
          end
        end
        ST_FCS: begin
          mii_txd <= fcs_nib;
          fcs_idx <= fcs_idx + 3'd1;
          if (fcs_idx == 3'd7) begin
            cnt   <= '0;
            state <= ST_IFG;
          end
        end
        ST_IFG: begin
          mii_tx_en <= 1'b0;
          mii_txd   <= '0;
          cnt       <= cnt + 5'd1;
          if (cnt == IFG_LAST) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
